// File: rtl/wordcount_pkg.sv
// Shared types and default sizing for the word-count accumulator datapath.
package wordcount_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 14;
   localparam int unsigned DEF_DATA_WIDTH = 64;
   localparam int unsigned REQ_ADDR_WIDTH = 32;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers who was granted last
// and only moves when a grant is actually issued.
module rr_arbiter2 (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   input  logic req_a_i,
   input  logic req_b_i,
   output logic gnt_a_o,
   output logic gnt_b_o
);

   logic last_b_q, last_b_d;

   always_comb begin
      last_b_d = last_b_q;
      gnt_a_o  = en_i & req_a_i & (~req_b_i | last_b_q);
      gnt_b_o  = en_i & req_b_i & (~req_a_i | ~last_b_q);
      if (gnt_a_o) begin
         last_b_d = 1'b0;
      end else if (gnt_b_o) begin
         last_b_d = 1'b1;
      end
   end

   // Reset to "B granted last" so A wins the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_b_q <= 1'b1;
      end else begin
         last_b_q <= last_b_d;
      end
   end

endmodule

// File: rtl/accum_arbiter.sv
// Two-requester front end for the accumulator RAM with a zero-fill engine
// and a sticky out-of-range address flag.
module accum_arbiter
   import wordcount_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      clear_kick,
   output logic                      clear_busy,
   input  logic                      a_valid,
   output logic                      a_ready,
   input  logic                      a_we,
   input  logic [REQ_ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0]     a_din,
   output logic                      a_rvalid,
   output logic [DATA_WIDTH-1:0]     a_q,
   input  logic                      b_valid,
   output logic                      b_ready,
   input  logic                      b_we,
   input  logic [REQ_ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0]     b_din,
   output logic                      b_rvalid,
   output logic [DATA_WIDTH-1:0]     b_q,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_din,
   output logic                      mem_we,
   input  logic [DATA_WIDTH-1:0]     mem_q,
   output logic                      oor_err
);

   localparam logic [REQ_ADDR_WIDTH:0] DEPTH = (REQ_ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

   state_e                      state_q, state_d;
   logic [ADDR_WIDTH-1:0]       clr_cnt_q, clr_cnt_d;
   logic                        a_rv_q, a_rv_d;
   logic                        b_rv_q, b_rv_d;
   logic                        rd_oor_q, rd_oor_d;
   logic                        oor_q, oor_d;
   logic                        arb_en, gnt_a, gnt_b;
   logic                        sel_we, sel_oor;
   logic [REQ_ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]       sel_din;

   // clear_kick pre-empts arbitration in the cycle it is seen.
   assign arb_en = (state_q == ST_ARB) && !clear_kick;

   rr_arbiter2 u_rr (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (arb_en),
      .req_a_i (a_valid),
      .req_b_i (b_valid),
      .gnt_a_o (gnt_a),
      .gnt_b_o (gnt_b)
   );

   assign a_ready  = gnt_a;
   assign b_ready  = gnt_b;
   assign sel_addr = gnt_b ? b_addr : a_addr;
   assign sel_din  = gnt_b ? b_din  : a_din;
   assign sel_we   = gnt_b ? b_we   : a_we;
   assign sel_oor  = {1'b0, sel_addr} >= DEPTH;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      oor_d     = oor_q;
      a_rv_d    = 1'b0;
      b_rv_d    = 1'b0;
      rd_oor_d  = 1'b0;
      mem_addr  = '0;
      mem_din   = '0;
      mem_we    = 1'b0;
      case (state_q)
         ST_ARB: begin
            if (clear_kick) begin
               state_d = ST_CLEAR;
            end else if (gnt_a || gnt_b) begin
               a_rv_d   = gnt_a & ~a_we;
               b_rv_d   = gnt_b & ~b_we;
               rd_oor_d = sel_oor;
               if (sel_oor) begin
                  oor_d = 1'b1;
               end else begin
                  mem_addr = sel_addr[ADDR_WIDTH-1:0];
                  mem_din  = sel_din;
                  mem_we   = sel_we;
               end
            end
         end
         ST_CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = clr_cnt_q;
            if (clr_cnt_q == '1) begin
               clr_cnt_d = '0;
               state_d   = ST_ARB;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_ARB;
         clr_cnt_q <= '0;
         a_rv_q    <= 1'b0;
         b_rv_q    <= 1'b0;
         rd_oor_q  <= 1'b0;
         oor_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         a_rv_q    <= a_rv_d;
         b_rv_q    <= b_rv_d;
         rd_oor_q  <= rd_oor_d;
         oor_q     <= oor_d;
      end
   end

   // Out-of-range reads still complete on schedule but return zero.
   assign a_rvalid   = a_rv_q;
   assign b_rvalid   = b_rv_q;
   assign a_q        = (a_rv_q && !rd_oor_q) ? mem_q : '0;
   assign b_q        = (b_rv_q && !rd_oor_q) ? mem_q : '0;
   assign clear_busy = (state_q == ST_CLEAR);
   assign oor_err    = oor_q;

endmodule
